// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter driving one shared APB master port (optional: APB_ARB_TIMEOUT_EN)
module apb_master_arbiter #(
  parameter int G_NUM_REQ        = 4,
  parameter int G_APB_ADDR_WIDTH = 32,
  parameter int G_APB_DATA_WIDTH = 32,
  parameter int G_TIMEOUT        = 256
) (
  input  logic                                   pclk,
  input  logic                                   preset,
  input  logic [G_NUM_REQ-1:0]                   req_valid,
  input  logic [G_NUM_REQ-1:0]                   req_write,
  input  logic [G_NUM_REQ*G_APB_ADDR_WIDTH-1:0]  req_addr,
  input  logic [G_NUM_REQ*G_APB_DATA_WIDTH-1:0]  req_wdata,
  output logic [G_NUM_REQ-1:0]                   req_ready,
  output logic [G_NUM_REQ-1:0]                   rsp_valid,
  output logic [G_APB_DATA_WIDTH-1:0]            rsp_rdata,
  output logic                                   rsp_err,
  output logic [G_APB_ADDR_WIDTH-1:0]            paddr,
  output logic [2:0]                             pprot,
  output logic                                   psel,
  output logic                                   penable,
  output logic                                   pwrite,
  output logic [G_APB_DATA_WIDTH-1:0]            pwdata,
  input  logic                                   pready,
  input  logic [G_APB_DATA_WIDTH-1:0]            prdata,
  input  logic                                   pslverr
);

  localparam int IW = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1;
  localparam logic [G_NUM_REQ-1:0] ONE_HOT0 = {{(G_NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                        state_q;
  logic [IW-1:0]                 last_grant_q;
  logic [G_APB_ADDR_WIDTH-1:0]   paddr_q;
  logic                          pwrite_q;
  logic [G_APB_DATA_WIDTH-1:0]   pwdata_q;
  logic                          psel_q;
  logic                          penable_q;
  logic [G_NUM_REQ-1:0]          req_ready_q;
  logic [G_NUM_REQ-1:0]          rsp_valid_q;
  logic [G_APB_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                          rsp_err_q;

  logic [IW-1:0]                 grant_idx_d;
  logic                          grant_vld_d;
  logic [IW-1:0]                 cand_idx;
  logic [G_APB_ADDR_WIDTH-1:0]   win_addr_d;
  logic [G_APB_DATA_WIDTH-1:0]   win_wdata_d;
  logic                          win_write_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;
  logic [TW-1:0]                 tmo_cnt_q;
`else
  logic                          timeout_unused;
  assign timeout_unused = (G_TIMEOUT > 0);
`endif

  // Round-robin search: first requester set, starting just after the last winner
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    cand_idx    = '0;
    for (int k = 1; k <= G_NUM_REQ; k++) begin
      cand_idx = IW'((int'(last_grant_q) + k) % G_NUM_REQ);
      if (!grant_vld_d && req_valid[cand_idx]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = cand_idx;
      end
    end
  end

  // Payload of the current round-robin winner
  always_comb begin
    win_addr_d  = req_addr[int'(grant_idx_d)*G_APB_ADDR_WIDTH +: G_APB_ADDR_WIDTH];
    win_write_d = req_write[grant_idx_d];
    win_wdata_d = win_write_d ? req_wdata[int'(grant_idx_d)*G_APB_DATA_WIDTH +: G_APB_DATA_WIDTH]
                              : '0;
  end

  // Transfer sequencer: IDLE arbitrates, SETUP lasts one cycle, ACCESS waits for pready
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(G_NUM_REQ - 1);
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      // Handshake and response strobes are single-cycle pulses
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            paddr_q      <= win_addr_d;
            pwrite_q     <= win_write_d;
            pwdata_q     <= win_wdata_d;
            psel_q       <= 1'b1;
            penable_q    <= 1'b0;
            req_ready_q  <= ONE_HOT0 << grant_idx_d;
            last_grant_q <= grant_idx_d;
            state_q      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          // last_grant_q still names the owner of the transfer in flight
          if (pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= ONE_HOT0 << last_grant_q;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
            rsp_err_q   <= pslverr;
            state_q     <= ST_IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TW'(G_TIMEOUT - 1)) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= ONE_HOT0 << last_grant_q;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pprot     = 3'b000;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            pclk = 1'b0;
  logic            preset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   paddr;
  logic [2:0]      pprot;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic            pready = 1'b1;
  logic [DW-1:0]   prdata = '0;
  logic            pslverr = 1'b0;

  int tests = 0;
  int failed = 0;

  apb_master_arbiter #(
    .G_NUM_REQ(N), .G_APB_ADDR_WIDTH(AW), .G_APB_DATA_WIDTH(DW), .G_TIMEOUT(8)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    preset = 1'b1; req_valid = '0; pready = 1'b1; pslverr = 1'b0; prdata = '0;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    @(negedge pclk);
    tests++;
    if ({psel, penable, pwrite, req_ready, rsp_valid, rsp_err} !== 12'h000) begin
      failed++;
      $display("FAIL reset_ctrl: got %h expected 000", {psel, penable, pwrite, req_ready, rsp_valid, rsp_err});
    end
    tests++;
    if ({paddr, pwdata, rsp_rdata, pprot} !== 99'h0) begin
      failed++;
      $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, rsp_rdata, pprot});
    end
    preset = 1'b0;
  endtask

  task automatic test_single_write();
    pready = 1'b1;
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    @(negedge pclk);
    tests++;
    if ({psel, penable, req_ready, pwrite} !== 7'b1_0_0001_1) begin
      failed++;
      $display("FAIL wr_setup: got %b expected 1000011", {psel, penable, req_ready, pwrite});
    end
    tests++;
    if ({paddr, pwdata, pprot} !== {32'h10, 32'hA5A5_0001, 3'b000}) begin
      failed++;
      $display("FAIL wr_payload: got %h/%h/%b expected 10/a5a50001/000", paddr, pwdata, pprot);
    end
    req_valid = '0;
    @(negedge pclk);
    tests++;
    if ({psel, penable, req_ready} !== 6'b11_0000) begin
      failed++;
      $display("FAIL wr_access: got %b expected 110000", {psel, penable, req_ready});
    end
    @(negedge pclk);
    tests++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata} !== {2'b00, 4'b0001, 1'b0, 32'h0}) begin
      failed++;
      $display("FAIL wr_rsp: got %b %b %b %h expected 00 0001 0 0", {psel, penable}, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge pclk);
    tests++;
    if (rsp_valid !== 4'b0000) begin
      failed++;
      $display("FAIL wr_rsp_pulse: got %b expected 0000", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    int gcyc [5];
    int gidx [5];
    int gcnt;
    int idx;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    gcnt = 0;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i));
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge pclk);
      if (req_ready != '0) begin
        idx = -1;
        for (int j = 0; j < N; j++) if (req_ready[j]) idx = j;
        if (gcnt < 5) begin
          gcyc[gcnt] = cyc;
          gidx[gcnt] = idx;
          tests++;
          if (paddr !== 32'h100 + 32'(4*exp_order[gcnt])) begin
            failed++;
            $display("FAIL rr_paddr%0d: got %h expected %h", gcnt, paddr, 32'h100 + 32'(4*exp_order[gcnt]));
          end
        end
        gcnt++;
      end
    end
    req_valid = '0;
    tests++;
    if (gcnt != 5) begin
      failed++;
      $display("FAIL rr_count: got %0d expected 5", gcnt);
    end
    for (int g = 0; g < 5 && g < gcnt; g++) begin
      tests++;
      if (gidx[g] != exp_order[g] || gcyc[g] != 1 + 3*g) begin
        failed++;
        $display("FAIL rr_grant%0d: got req %0d at cycle %0d expected req %0d at cycle %0d",
                 g, gidx[g], gcyc[g], exp_order[g], 1 + 3*g);
      end
    end
    @(negedge pclk);
    tests++;
    if ({psel, req_ready} !== 5'b0) begin
      failed++;
      $display("FAIL rr_idle: got %b expected 00000", {psel, req_ready});
    end
  endtask

  task automatic test_wait_states();
    pready = 1'b0;
    set_req(2, 1'b0, 32'h20, 32'hFFFF_FFFF);
    @(negedge pclk);
    tests++;
    if ({req_ready, psel, penable, pwrite, paddr, pwdata} !== {4'b0100, 3'b100, 32'h20, 32'h0}) begin
      failed++;
      $display("FAIL ws_setup: got %b %b %h %h expected 0100 100 20 0", req_ready, {psel, penable, pwrite}, paddr, pwdata);
    end
    req_valid = '0;
    @(negedge pclk);
    for (int w = 0; w < 3; w++) begin
      @(negedge pclk);
      tests++;
      if ({psel, penable, paddr, rsp_valid} !== {2'b11, 32'h20, 4'b0000}) begin
        failed++;
        $display("FAIL ws_hold%0d: got %b %h %b expected 11 20 0000", w, {psel, penable}, paddr, rsp_valid);
      end
    end
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    @(negedge pclk);
    tests++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata} !== {2'b00, 4'b0100, 1'b0, 32'hDEAD_BEEF}) begin
      failed++;
      $display("FAIL ws_rsp: got %b %b %b %h expected 00 0100 0 deadbeef", {psel, penable}, rsp_valid, rsp_err, rsp_rdata);
    end
    prdata = '0;
    @(negedge pclk);
    tests++;
    if ({rsp_valid, rsp_rdata} !== 36'h0) begin
      failed++;
      $display("FAIL ws_rsp_clear: got %b %h expected 0000 0", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_slave_error();
    pready = 1'b1;
    set_req(1, 1'b1, 32'h30, 32'h1234_5678);
    @(negedge pclk);
    tests++;
    if (req_ready !== 4'b0010) begin
      failed++;
      $display("FAIL err_grant: got %b expected 0010", req_ready);
    end
    req_valid = '0;
    @(negedge pclk);
    pslverr = 1'b1;
    @(negedge pclk);
    tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0010, 1'b1, 32'h0}) begin
      failed++;
      $display("FAIL err_rsp: got %b %b %h expected 0010 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    pslverr = 1'b0;
    prdata = 32'h0BAD_F00D;
    set_req(3, 1'b0, 32'h40, 32'h0);
    set_req(1, 1'b1, 32'h44, 32'h4444_4444);
    @(negedge pclk);
    tests++;
    if ({req_ready, paddr, pwrite} !== {4'b1000, 32'h40, 1'b0}) begin
      failed++;
      $display("FAIL err_next_grant: got %b %h %b expected 1000 40 0", req_ready, paddr, pwrite);
    end
    req_valid = '0;
    repeat (2) @(negedge pclk);
    tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b1000, 1'b0, 32'h0BAD_F00D}) begin
      failed++;
      $display("FAIL err_next_rsp: got %b %b %h expected 1000 0 0badf00d", rsp_valid, rsp_err, rsp_rdata);
    end
    prdata = '0;
    @(negedge pclk);
  endtask

  task automatic test_reset_in_access();
    pready = 1'b0;
    set_req(1, 1'b0, 32'h50, 32'h0);
    @(negedge pclk);
    req_valid = '0;
    @(negedge pclk);
    set_req(0, 1'b1, 32'h60, 32'h6666_0000);
    set_req(3, 1'b1, 32'h70, 32'h7777_0000);
    @(negedge pclk);
    tests++;
    if ({psel, penable, req_ready} !== 6'b11_0000) begin
      failed++;
      $display("FAIL rst_pending_ignored: got %b expected 110000", {psel, penable, req_ready});
    end
    preset = 1'b1;
    #1;
    tests++;
    if ({psel, penable, req_ready, rsp_valid, rsp_err} !== 11'h0) begin
      failed++;
      $display("FAIL rst_async: got %b expected 0", {psel, penable, req_ready, rsp_valid, rsp_err});
    end
    @(negedge pclk);
    preset = 1'b0;
    pready = 1'b1;
    @(negedge pclk);
    tests++;
    if ({req_ready, paddr, psel} !== {4'b0001, 32'h60, 1'b1}) begin
      failed++;
      $display("FAIL rst_first_prio: got %b %h %b expected 0001 60 1", req_ready, paddr, psel);
    end
    req_valid = '0;
    repeat (2) @(negedge pclk);
    tests++;
    if (rsp_valid !== 4'b0001) begin
      failed++;
      $display("FAIL rst_rsp_owner: got %b expected 0001", rsp_valid);
    end
    @(negedge pclk);
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    pready = 1'b0;
    set_req(2, 1'b1, 32'h80, 32'h8888_0000);
    @(negedge pclk);
    req_valid = '0;
    @(negedge pclk);
    for (int k = 0; k < 7; k++) begin
      @(negedge pclk);
      tests++;
      if ({psel, penable, rsp_valid} !== 6'b11_0000) begin
        failed++;
        $display("FAIL tmo_wait%0d: got %b expected 110000", k, {psel, penable, rsp_valid});
      end
    end
    @(negedge pclk);
    tests++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata} !== {2'b00, 4'b0100, 1'b1, 32'h0}) begin
      failed++;
      $display("FAIL tmo_abort: got %b %b %b %h expected 00 0100 1 0", {psel, penable}, rsp_valid, rsp_err, rsp_rdata);
    end
    pready = 1'b1;
    prdata = 32'hFFFF_FFFF;
    @(negedge pclk);
    tests++;
    if ({psel, rsp_valid, rsp_err} !== 6'b0) begin
      failed++;
      $display("FAIL tmo_late_pready: got %b expected 000000", {psel, rsp_valid, rsp_err});
    end
    prdata = '0;
  endtask
`else
  task automatic test_no_timeout();
    pready = 1'b0;
    set_req(2, 1'b1, 32'h80, 32'h8888_0000);
    @(negedge pclk);
    req_valid = '0;
    @(negedge pclk);
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      tests++;
      if ({psel, penable, rsp_valid} !== 6'b11_0000) begin
        failed++;
        $display("FAIL notmo_wait%0d: got %b expected 110000", k, {psel, penable, rsp_valid});
      end
    end
    pready = 1'b1;
    @(negedge pclk);
    tests++;
    if ({psel, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 4'b0100, 1'b0, 32'h0}) begin
      failed++;
      $display("FAIL notmo_rsp: got %b %b %b %h expected 0 0100 0 0", psel, rsp_valid, rsp_err, rsp_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_wait_states();
    test_slave_error();
    test_reset_in_access();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares one APB master port between G_NUM_REQ command-driven requesters, such as several script-driven CPU models or DMA stubs.
Round-robin arbitration selects one request at a time. The block sequences it through the APB SETUP/ACCESS phases and returns read data and error status to the winning requester.
The block sits between the requester models and the APB interconnect. It is the only block that drives psel/penable on that bus.

Parameters:
G_NUM_REQ, 4, number of requesters (2..16)
G_APB_ADDR_WIDTH, 32, APB address width
G_APB_DATA_WIDTH, 32, APB data width
G_TIMEOUT, 256, maximum ACCESS cycles before abort (used only with APB_ARB_TIMEOUT_EN)

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  reset; asynchronous, active-high (single clock domain)
req_valid  in  G_NUM_REQ  per-requester request; held with payload until req_ready
req_write  in  G_NUM_REQ  1=write, 0=read
req_addr  in  G_NUM_REQ*G_APB_ADDR_WIDTH  packed addresses; requester i at slice i
req_wdata  in  G_NUM_REQ*G_APB_DATA_WIDTH  packed write data
req_ready  out  G_NUM_REQ  one-hot, one-cycle accept pulse
rsp_valid  out  G_NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  G_APB_DATA_WIDTH  read data; valid while any rsp_valid bit is high
rsp_err  out  1  pslverr or timeout; valid with rsp_valid
paddr  out  G_APB_ADDR_WIDTH  APB address
pprot  out  3  constant 3'b000
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  G_APB_DATA_WIDTH  APB write data; 0 for reads
pready  in  1  APB slave ready
prdata  in  G_APB_DATA_WIDTH  APB read data
pslverr  in  1  APB slave error

Behaviour:
- Reset (preset=1, asynchronous): state=IDLE and every output is 0. The round-robin pointer last_grant is set to G_NUM_REQ-1, so requester 0 has first priority. A transfer in flight is dropped and no rsp_valid is issued.
- States: IDLE, SETUP, ACCESS; all registered, one-hot or binary encoding allowed.
- IDLE:
  - If any req_valid bit is set, the winner is the first set bit scanning from last_grant+1 modulo G_NUM_REQ, wrapping around.
  - On the next edge: capture the winner's addr/write/wdata into paddr/pwrite/pwdata, set psel=1 and penable=0, pulse req_ready[winner] for one cycle, set last_grant=winner, go to SETUP.
  - If no req_valid bit is set, stay in IDLE with psel=0.
- SETUP: for exactly one cycle, set penable=1 and go to ACCESS.
- ACCESS:
  - While pready=0, hold all APB outputs stable.
  - On the edge where pready=1: psel=0, penable=0, rsp_valid[winner]=1, rsp_rdata=prdata for reads or 0 for writes, rsp_err=pslverr. Go to IDLE.
- rsp_valid, rsp_rdata and rsp_err last one cycle, then return to 0.
- Latency: req_valid first seen at edge 0 gives psel at edge 1 and penable at edge 2. With zero wait states (pready=1 at edge 3), rsp_valid is high for the cycle after edge 3.
- Peak throughput is one transfer per 3 cycles, because every transfer passes through at least one IDLE cycle.
- Requesters must deassert or update req_valid in the cycle after req_ready. Requests present in SETUP or ACCESS are ignored and not latched.
- A requester that withdraws req_valid before it is granted is never granted. Dropping req_valid while in IDLE is legal.
- If req_valid bits change while in IDLE, arbitration samples only the value at the capture edge.
- pprot is tied to 3'b000.

Optional Feature:
APB_ARB_TIMEOUT_EN
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0. When it reaches G_TIMEOUT-1 with pready still 0, the next edge aborts the transfer: psel=0, penable=0, rsp_valid[winner]=1, rsp_err=1, rsp_rdata=0, state=IDLE. A late pready after the abort is ignored.
- Undefined: no counter is built and G_TIMEOUT is unused. ACCESS waits on pready indefinitely.

Test Plan:
1. Reset, then req 0 writes addr 0x10 data 0xA5A5_0001 with pready=1 → psel edges 1–3, penable edges 2–3, pwrite=1, pwdata=0xA5A5_0001, rsp_valid=4'b0001, rsp_err=0.
2. Reqs 0–3 all valid continuously and re-requesting after each req_ready → grant order 0,1,2,3,0; each transfer 3 cycles apart.
3. Req 2 reads 0x20, slave inserts 3 wait states and returns prdata=0xDEAD_BEEF → paddr/psel stable for 4 ACCESS cycles; rsp_valid[2]=1, rsp_rdata=0xDEAD_BEEF.
4. Write with pslverr=1 on the pready cycle → rsp_err=1 with rsp_valid; the next request arbitrates normally.
5. preset asserted during ACCESS wait states → psel/penable/req_ready/rsp_valid are 0 immediately; after release, req 0 wins even if req 3 was pending.
6. With APB_ARB_TIMEOUT_EN and G_TIMEOUT=8, pready held 0 → abort after 8 ACCESS cycles: rsp_err=1, rsp_rdata=0, psel=0.
